// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller: FSM encoding and default geometry.
package imem_ctrl_pkg;
  localparam int IMEM_ADDR_W = 10;
  localparam int XLEN        = 32;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/imem_ctrl_if.sv
// Loader link, memory ports and front-end fetch handshake of imem_ctrl in one bundle.
interface imem_ctrl_if #(
  parameter int ADDR_W = imem_ctrl_pkg::IMEM_ADDR_W,
  parameter int DATA_W = imem_ctrl_pkg::XLEN
) ();
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic [DATA_W-1:0] mem_data_in;
  logic [ADDR_W-1:0] mem_addr_w;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_data_out;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W+1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W+1:0] redirect_pc;
  logic              cpu_halt;
  logic [ADDR_W:0]   words_loaded;
  logic              load_err;

  modport slave (
    input  ld_start, ld_valid, ld_byte, ld_last, mem_data_out, inst_ready,
           redirect_valid, redirect_pc,
    output ld_ready, mem_data_in, mem_addr_w, mem_addr_r, inst_valid, inst_data,
           inst_pc, cpu_halt, words_loaded, load_err
  );

  modport master (
    output ld_start, ld_valid, ld_byte, ld_last, mem_data_out, inst_ready,
           redirect_valid, redirect_pc,
    input  ld_ready, mem_data_in, mem_addr_w, mem_addr_r, inst_valid, inst_data,
           inst_pc, cpu_halt, words_loaded, load_err
  );
endinterface

// File: rtl/imem_fetch_seq.sv
// Fetch sequencer: next-PC selection feeding the memory read port, and the PC/valid of the word
// the memory returns one cycle later.
module imem_fetch_seq #(
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              flush,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W+1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr_r,
  output logic [ADDR_W+1:0] f_pc,
  output logic              f_valid
);
  localparam int PCW = ADDR_W + 2;
  localparam logic [PCW-1:0] PC0 = PCW'(RESET_PC);

  logic [PCW-1:0] nxt_pc;
  logic [1:0]     unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[1:0];

  always_comb begin
    nxt_pc = f_pc;
    if (redirect_valid)                nxt_pc = {redirect_pc[PCW-1:2], 2'b00};
    else if (f_valid && !inst_ready)   nxt_pc = f_pc;
    else if (f_valid)                  nxt_pc = f_pc + PCW'(4);
  end

  // The read address is the registered PC outside RUN so the memory port stays quiet.
  assign mem_addr_r = run ? nxt_pc[PCW-1:2] : f_pc[PCW-1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc    <= PC0;
      f_valid <= 1'b0;
    end else if (!run) begin
      f_pc    <= PC0;
      f_valid <= 1'b0;
    end else if (flush) begin
      f_valid <= 1'b0;
    end else begin
      f_pc    <= nxt_pc;
      f_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory sequencer: byte-stream boot loader (LOAD), one-cycle write drain (DRAIN),
// then instruction fetch to decode (RUN).
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = IMEM_ADDR_W,
  parameter int          DATA_W    = XLEN,
  parameter int unsigned RESET_PC  = 0,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  imem_ctrl_if.slave bus
);
  localparam int BPW  = DATA_W / 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam state_t RST_ST = BOOT_LOAD ? ST_LOAD : ST_RUN;

  state_t                 state;
  logic                   ld_ready_q, cpu_halt_q, load_err_q;
  logic [BC_W-1:0]        byte_cnt;
  logic [BPW-1:0][7:0]    asm_q, asm_nxt;
  logic [ADDR_W:0]        words_loaded_q;
  logic [ADDR_W-1:0]      mem_addr_w_q;
  logic [DATA_W-1:0]      mem_data_in_q;
  logic                   accept, commit, full, run;
  logic [ADDR_W+1:0]      f_pc;
  logic                   f_valid;

  assign accept = bus.ld_valid & ld_ready_q;
  assign commit = accept & (bus.ld_last | (byte_cnt == BC_W'(BPW - 1)));
  assign full   = words_loaded_q[ADDR_W];
  assign run    = (state == ST_RUN);

  // Lanes above byte_cnt are still zero from the last commit, so a short final word pads with 0.
  always_comb begin
    asm_nxt           = asm_q;
    asm_nxt[byte_cnt] = bus.ld_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RST_ST;
      ld_ready_q     <= BOOT_LOAD;
      cpu_halt_q     <= BOOT_LOAD;
      load_err_q     <= 1'b0;
      byte_cnt       <= '0;
      asm_q          <= '0;
      words_loaded_q <= '0;
      mem_addr_w_q   <= '0;
      mem_data_in_q  <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (commit) begin
              asm_q    <= '0;
              byte_cnt <= '0;
              // Past the last word the write pair is frozen, so the memory only rewrites it.
              if (full) begin
                load_err_q <= 1'b1;
              end else begin
                mem_data_in_q  <= asm_nxt;
                mem_addr_w_q   <= words_loaded_q[ADDR_W-1:0];
                words_loaded_q <= words_loaded_q + (ADDR_W + 1)'(1);
              end
            end else begin
              asm_q    <= asm_nxt;
              byte_cnt <= byte_cnt + BC_W'(1);
            end
            if (bus.ld_last) begin
              state      <= ST_DRAIN;
              ld_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          state      <= ST_RUN;
          cpu_halt_q <= 1'b0;
        end
        ST_RUN: begin
          if (bus.ld_start) begin
            state          <= ST_LOAD;
            ld_ready_q     <= 1'b1;
            cpu_halt_q     <= 1'b1;
            load_err_q     <= 1'b0;
            byte_cnt       <= '0;
            asm_q          <= '0;
            words_loaded_q <= '0;
          end
        end
        default: state <= RST_ST;
      endcase
    end
  end

  imem_fetch_seq #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .flush          (bus.ld_start),
    .inst_ready     (bus.inst_ready),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .mem_addr_r     (bus.mem_addr_r),
    .f_pc           (f_pc),
    .f_valid        (f_valid)
  );

  assign bus.ld_ready     = ld_ready_q;
  assign bus.cpu_halt     = cpu_halt_q;
  assign bus.load_err     = load_err_q;
  assign bus.words_loaded = words_loaded_q;
  assign bus.mem_addr_w   = mem_addr_w_q;
  assign bus.mem_data_in  = mem_data_in_q;
  assign bus.inst_valid   = f_valid & run;
  assign bus.inst_pc      = f_pc;
  assign bus.inst_data    = bus.mem_data_out;
endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a 1K x 32 always-write, registered-read memory model.
module tb_imem_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  imem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .BOOT_LOAD(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Read returns pre-write contents on a same-edge read/write.
  always @(posedge clk) begin
    bus.mem_data_out <= mem[bus.mem_addr_r];
    mem[bus.mem_addr_w] <= bus.mem_data_in;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  function automatic logic [31:0] wv(input int i);
    logic [31:0] u;
    u = i;
    return {~u[7:0], 8'hC3, u[15:8] ^ 8'h5A, u[7:0]};
  endfunction

  task automatic chk_inst(input string tag, input logic [11:0] pc, input logic [31:0] data);
    chk({tag, "_valid"}, 64'(bus.inst_valid), 64'(1'b1));
    chk({tag, "_pc"},    64'(bus.inst_pc),    64'(pc));
    chk({tag, "_data"},  64'(bus.inst_data),  64'(data));
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hF000_0000 | i;
    bus.mem_data_out   = '0;
    bus.ld_start       = 1'b0;
    bus.ld_valid       = 1'b0;
    bus.ld_byte        = '0;
    bus.ld_last        = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    chk("rst_ld_ready",  64'(bus.ld_ready),     64'(1'b1));
    chk("rst_cpu_halt",  64'(bus.cpu_halt),     64'(1'b1));
    chk("rst_inst_vld",  64'(bus.inst_valid),   64'(1'b0));
    chk("rst_words",     64'(bus.words_loaded), 64'(0));
    chk("rst_load_err",  64'(bus.load_err),     64'(1'b0));
    chk("rst_addr_w",    64'(bus.mem_addr_w),   64'(0));
    chk("rst_data_in",   64'(bus.mem_data_in),  64'(0));

    // 1: 8-byte image
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), i == 7);
    chk("t1_words",     64'(bus.words_loaded), 64'(2));
    chk("t1_addr_w",    64'(bus.mem_addr_w),   64'(1));
    chk("t1_data_in",   64'(bus.mem_data_in),  64'(32'h8877_6655));
    chk("t1_drain_hlt", 64'(bus.cpu_halt),     64'(1'b1));
    chk("t1_drain_rdy", 64'(bus.ld_ready),     64'(1'b0));
    tick();
    chk("t1_run_hlt",   64'(bus.cpu_halt),     64'(1'b0));
    chk("t1_mem0",      64'(mem[0]),           64'(32'h4433_2211));
    chk("t1_mem1",      64'(mem[1]),           64'(32'h8877_6655));
    chk("t1_inst_vld",  64'(bus.inst_valid),   64'(1'b0));

    // 2: reload with a 5-byte image
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("t2_ld_ready",  64'(bus.ld_ready),     64'(1'b1));
    chk("t2_inst_vld",  64'(bus.inst_valid),   64'(1'b0));
    chk("t2_words_clr", 64'(bus.words_loaded), 64'(0));
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hAA, 1'b1);
    chk("t2_words",     64'(bus.words_loaded), 64'(2));
    chk("t2_data_in",   64'(bus.mem_data_in),  64'(32'h0000_00AA));
    chk("t2_vld_c0",    64'(bus.inst_valid),   64'(1'b0));
    tick();
    chk("t2_vld_c1",    64'(bus.inst_valid),   64'(1'b0));
    tick();
    chk_inst("t2_first", 12'h000, 32'h0403_0201);
    chk("t2_mem1",      64'(mem[1]),           64'(32'h0000_00AA));

    // 3: free run
    bus.inst_ready = 1'b1;
    tick();
    chk_inst("t3_pc4", 12'h004, 32'h0000_00AA);
    tick();
    chk_inst("t3_pc8", 12'h008, 32'hF000_0002);

    // 4: stall 3 cycles at pc 8
    bus.inst_ready = 1'b0;
    #1;
    chk("t4_addr_r", 64'(bus.mem_addr_r), 64'(2));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_inst("t4_stall", 12'h008, 32'hF000_0002);
    end
    bus.inst_ready = 1'b1;
    tick();
    chk_inst("t4_pc12", 12'h00C, 32'hF000_0003);

    // 5: redirects
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 12'h004;
    tick();
    chk_inst("t5_pc4", 12'h004, 32'h0000_00AA);
    bus.redirect_pc = 12'h3FE;
    tick();
    chk_inst("t5_3fc", 12'h3FC, 32'hF000_00FF);
    bus.redirect_pc = 12'hFFC;
    tick();
    chk_inst("t5_ffc", 12'hFFC, 32'hF000_03FF);
    bus.redirect_valid = 1'b0;
    tick();
    chk_inst("t5_wrap", 12'h000, 32'h0403_0201);
    tick();
    chk_inst("t5_after", 12'h004, 32'h0000_00AA);

    // 6: overflow load of 1025 words
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("t6_ld_ready", 64'(bus.ld_ready),   64'(1'b1));
    chk("t6_inst_vld", 64'(bus.inst_valid), 64'(1'b0));
    for (int wi = 0; wi <= 1024; wi++) begin
      w = wv(wi);
      for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], (wi == 1024) && (k == 3));
    end
    chk("t6_load_err", 64'(bus.load_err),     64'(1'b1));
    chk("t6_words",    64'(bus.words_loaded), 64'(1024));
    chk("t6_addr_w",   64'(bus.mem_addr_w),   64'(1023));
    chk("t6_data_in",  64'(bus.mem_data_in),  64'(wv(1023)));
    tick();
    chk("t6_mem0",     64'(mem[0]),    64'(wv(0)));
    chk("t6_mem1",     64'(mem[1]),    64'(wv(1)));
    chk("t6_mem1023",  64'(mem[1023]), 64'(wv(1023)));
    chk("t6_err_run",  64'(bus.load_err), 64'(1'b1));
    tick();
    chk_inst("t6_fetch0", 12'h000, wv(0));
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("t6_rl_ready", 64'(bus.ld_ready),   64'(1'b1));
    chk("t6_rl_vld",   64'(bus.inst_valid), 64'(1'b0));
    chk("t6_rl_err",   64'(bus.load_err),   64'(1'b0));

    // async reset in the middle of a load
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 1'b0);
    chk("ar_words_pre", 64'(bus.words_loaded), 64'(1));
    chk("ar_data_pre",  64'(bus.mem_data_in),  64'(32'h3332_3130));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_words",    64'(bus.words_loaded), 64'(0));
    chk("ar_data_in",  64'(bus.mem_data_in),  64'(0));
    chk("ar_ld_ready", 64'(bus.ld_ready),     64'(1'b1));
    chk("ar_halt",     64'(bus.cpu_halt),     64'(1'b1));
    chk("ar_inst_vld", 64'(bus.inst_valid),   64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
